// File: rtl/serial_word_sender.sv
// ============================================================================
// serial_word_sender: LSB-first serialiser feeding a chain of 8-bit shift
// registers, with a shift clock, a latch strobe and a done pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_word_sender #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             s_dat,
  output logic             s_clk,
  output logic             latch,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             high_q, high_d;
  logic             s_dat_q, s_dat_d;
  logic             s_clk_q, s_clk_d;
  logic             latch_q, latch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    high_d  = high_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          word_d  = data_in;
          bit_d   = '0;
          phase_d = '0;
          high_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (phase_q == PW'(DIV - 1)) begin
          phase_d = '0;
          if (!high_q) begin
            high_d = 1'b1;
          end else begin
            // Bit period ends on the falling s_clk; next bit appears with it.
            high_d = 1'b0;
            word_d = word_q >> 1;
            bit_d  = bit_q + 1'b1;
            if (bit_q == BW'(WIDTH - 1)) begin
              state_d = LATCH;
              bit_d   = '0;
            end
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LATCH: begin
        if (phase_q == PW'(DIV - 1)) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    busy_d  = (state_d != IDLE);
    s_clk_d = (state_d == SHIFT) && high_d;
    s_dat_d = (state_d == SHIFT) && word_d[0];
    latch_d = (state_d == LATCH);
    done_d  = (state_q == LATCH) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      high_q  <= 1'b0;
      s_dat_q <= 1'b0;
      s_clk_q <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      high_q  <= high_d;
      s_dat_q <= s_dat_d;
      s_clk_q <= s_clk_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s_dat = s_dat_q;
  assign s_clk = s_clk_q;
  assign latch = latch_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: doc/serial_word_sender.md
SERIAL_WORD_SENDER -- requirements
Module: serial_word_sender

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the number of bits per transfer; legal range 1..32.
REQ-002 The block SHALL have parameter DIV, default 4, the clk cycles per s_clk half-period; legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic SHALL be clocked on the rising edge of clk.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  request to send data_in, sampled on a clk rising edge.
REQ-006 The block SHALL have port data_in  input  WIDTH  word to send, captured when start is accepted.
REQ-007 The block SHALL have port s_dat  output  1  serial data, driving the s_in of the downstream 8-bit shift register.
REQ-008 The block SHALL have port s_clk  output  1  shift clock; the downstream register shifts on its rising edge with S_L=0.
REQ-009 The block SHALL have port latch  output  1  word-complete strobe for downstream output registers.
REQ-010 The block SHALL have port busy  output  1  transfer in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 The block SHALL register every output, so no output is a combinational function of any input.
REQ-013 The block SHALL implement the states IDLE, SHIFT and LATCH.
REQ-014 In IDLE with start=1, the block SHALL capture data_in into an internal WIDTH-bit register, clear the bit counter and phase counter, and enter SHIFT.
REQ-015 The block SHALL ignore start whenever the state is not IDLE, and the captured word SHALL NOT change during a transfer.
REQ-016 The block SHALL send bits LSB first, so that after 8 downstream shifts the first bit sent sits at Q[0].
REQ-017 Each bit period in SHIFT SHALL be 2*DIV clk cycles: s_clk=0 for the first DIV cycles and s_clk=1 for the last DIV cycles.
REQ-018 s_dat SHALL hold the current bit for the whole bit period, so it is stable DIV cycles before and DIV cycles after each s_clk rising edge.
REQ-019 At the end of each bit period the block SHALL shift the internal register right by 1 and increment the bit counter.
REQ-020 After the bit period of bit WIDTH-1, the block SHALL enter LATCH; s_clk SHALL be 0 and s_dat SHALL be 0 in LATCH.
REQ-021 In LATCH, latch SHALL be 1 for exactly DIV cycles, after which the block SHALL return to IDLE.
REQ-022 busy SHALL be 1 in every cycle in which the state is SHIFT or LATCH, and 0 in IDLE.
REQ-023 done SHALL be 1 for exactly the first IDLE cycle after LATCH, and 0 otherwise.
REQ-024 A start asserted in the done cycle SHALL be accepted, giving back-to-back transfers with one idle cycle between them.
REQ-025 With the start-sampling edge as edge 0, busy SHALL be 1 in cycles 1 through WIDTH*2*DIV+DIV, and done SHALL be 1 in cycle WIDTH*2*DIV+DIV+1.
REQ-026 The block SHALL produce exactly WIDTH s_clk rising edges per transfer and none outside SHIFT.
REQ-027 The phase counter and bit counter SHALL be sized to hold DIV-1 and WIDTH-1 without overflow or wrap-around.
REQ-028 A start pulse longer than one cycle SHALL start one transfer only, unless start is still high in the done cycle.

Reset
REQ-029 While rst=1 at a clk edge, the block SHALL enter IDLE and force s_dat=0, s_clk=0, latch=0, busy=0 and done=0, and clear the internal register and both counters.
REQ-030 rst SHALL take priority over start, and start SHALL NOT be accepted in a cycle where rst=1.
REQ-031 rst asserted mid-transfer (SHIFT or LATCH) SHALL abort the transfer with no latch pulse and no done pulse.

Verification
REQ-032 The bench SHALL check that, with WIDTH=8, DIV=2 and data_in=8'hA5 with a 1-cycle start, s_dat at the 8 s_clk rising edges is 1,0,1,0,0,1,0,1, latch=1 in cycles 33-34, done=1 in cycle 35, and a chained ShiftReg8b Q=8'hA5.
REQ-033 The bench SHALL check that, with WIDTH=8 and DIV=1, a start held for 3 cycles gives exactly one transfer, with busy=1 in cycles 1-17 and done=1 in cycle 18.
REQ-034 The bench SHALL check that, with WIDTH=8 and DIV=2, rst asserted in cycle 10 gives busy=0, s_clk=0 and s_dat=0 one edge later, and no latch or done pulse.
REQ-035 The bench SHALL check that a start held high through the done cycle with data 8'h01 and then 8'h80 gives two transfers whose s_dat sequences are 1,0,0,0,0,0,0,0 and 0,0,0,0,0,0,0,1.
REQ-036 The bench SHALL check that changing data_in during SHIFT does not alter the s_dat sequence, and that a start during busy is ignored.
REQ-037 The bench SHALL check that, with WIDTH=16 and DIV=4, a transfer gives exactly 16 s_clk rising edges and done in cycle 133.
